gpio_pio_avs: RTL and testbench



---
 rtl/gpio_pio_avs.sv | 159 +++++++++++++++
 tb/tb_gpio_pio_avs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pio_avs.sv
// Avalon-MM GPIO slave: LED outputs with atomic set/clear, synchronised switch/key inputs,
// key falling-edge capture and a maskable level interrupt. Define GPIO_DEBOUNCE_EN to add per-bit debouncers.
module gpio_pio_avs #(
    parameter int OUT_W     = 8,
    parameter int SW_W      = 8,
    parameter int KEY_W     = 2,
    parameter int DB_CYCLES = 50000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [OUT_W-1:0]  led_export,
    input  logic [SW_W-1:0]   switch_export,
    input  logic [KEY_W-1:0]  key_export,
    output logic              irq
);

    typedef enum logic [2:0] {
        A_LED  = 3'd0,
        A_SW   = 3'd1,
        A_KEY  = 3'd2,
        A_EDGE = 3'd3,
        A_MASK = 3'd4,
        A_SET  = 3'd5,
        A_CLR  = 3'd6,
        A_NONE = 3'd7
    } addr_e;

    if (OUT_W < 1 || OUT_W > 32 || SW_W < 1 || SW_W > 32 ||
        KEY_W < 1 || KEY_W > 32 || DB_CYCLES < 2) begin : g_bad_param
        $error("gpio_pio_avs: parameter out of range");
    end

    // Switches and keys share one input vector; keys idle high (released).
    localparam int              IN_W   = SW_W + KEY_W;
    localparam logic [IN_W-1:0] IN_RST = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

    addr_e            w_addr;
    logic [IN_W-1:0]  w_raw;
    logic [IN_W-1:0]  r_sync1;
    logic [IN_W-1:0]  r_sync2;
    logic [IN_W-1:0]  w_stable;
    logic [IN_W-1:0]  w_stable_next;
    logic [KEY_W-1:0] w_key_fall;
    logic [KEY_W-1:0] w_edge_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    logic [OUT_W-1:0] r_led;
    logic [KEY_W-1:0] r_mask;
    logic [KEY_W-1:0] r_edge;
    logic [31:0]      r_readdata;

    assign w_addr = addr_e'(avs_address);
    assign w_raw  = {key_export, switch_export};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sync1 <= IN_RST;
            r_sync2 <= IN_RST;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [IN_W-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt [IN_W];

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        w_stable_next = r_stable;
        for (int i = 0; i < IN_W; i++) begin
            if (r_sync2[i] != r_stable[i] && r_cnt[i] == CNT_LAST) begin
                w_stable_next[i] = r_sync2[i];
            end
        end
    end

    // NOTE: the counter array is small and must restart from zero, so every element is reset explicitly.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_stable <= IN_RST;
            for (int i = 0; i < IN_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_next;
            for (int i = 0; i < IN_W; i++) begin
                if (r_sync2[i] == r_stable[i] || r_cnt[i] == CNT_LAST) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable      = r_sync2;
    assign w_stable_next = r_sync1;
`endif

    // A key edge is detected on the value the stable register is about to take.
    assign w_key_fall = w_stable[IN_W-1:SW_W] & ~w_stable_next[IN_W-1:SW_W];
    assign w_edge_clr = (avs_write && w_addr == A_EDGE) ? avs_writedata[KEY_W-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_LED:   w_rdata[OUT_W-1:0] = r_led;
            A_SW:    w_rdata[SW_W-1:0]  = w_stable[SW_W-1:0];
            A_KEY:   w_rdata[KEY_W-1:0] = w_stable[IN_W-1:SW_W];
            A_EDGE:  w_rdata[KEY_W-1:0] = r_edge;
            A_MASK:  w_rdata[KEY_W-1:0] = r_mask;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_led      <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
        end else begin
            if (avs_write) begin
                case (w_addr)
                    A_LED:   r_led  <= avs_writedata[OUT_W-1:0];
                    A_SET:   r_led  <= r_led | avs_writedata[OUT_W-1:0];
                    A_CLR:   r_led  <= r_led & ~avs_writedata[OUT_W-1:0];
                    A_MASK:  r_mask <= avs_writedata[KEY_W-1:0];
                    default: ;
                endcase
            end
            // A new edge overrides a same-cycle clear of that bit.
            r_edge <= (r_edge & ~w_edge_clr) | w_key_fall;
            if (avs_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign avs_readdata = r_readdata;
    assign led_export   = r_led;
    assign irq          = |(r_edge & r_mask);
    assign w_unused     = ^{avs_writedata, w_stable_next};

endmodule

// File: tb/tb_gpio_pio_avs.sv
// Directed bench for gpio_pio_avs; bus reads go through an expected-value queue.
// Expected input latency follows GPIO_DEBOUNCE_EN.
module tb_gpio_pio_avs;

    localparam int OUT_W = 8;
    localparam int SW_W  = 8;
    localparam int KEY_W = 2;
    localparam int DB    = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic              clk_clk;
    logic              reset_reset;
    logic [2:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [OUT_W-1:0]  led_export;
    logic [SW_W-1:0]   switch_export;
    logic [KEY_W-1:0]  key_export;
    logic              irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_checks = 0;
    int      n_bad    = 0;

    gpio_pio_avs #(
        .OUT_W     (OUT_W),
        .SW_W      (SW_W),
        .KEY_W     (KEY_W),
        .DB_CYCLES (DB)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .led_export    (led_export),
        .switch_export (switch_export),
        .key_export    (key_export),
        .irq           (irq)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic pop_and_check();
        rd_exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, avs_readdata, e.exp);
        end
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        sb.push_back('{tag: tag, exp: exp});
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        pop_and_check();
    endtask

    initial begin
        reset_reset   = 1'b1;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        switch_export = '0;
        key_export    = '1;

        // Reset state
        tick(2);
        reset_reset = 1'b0;
        check("rst_led", 32'(led_export), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", avs_readdata, 32'h0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), (a == 2) ? 32'h3 : 32'h0, $sformatf("rst_rd%0d", a));
        end

        // LED write, set, clear
        bus_write(3'd0, 32'h0000_000F);
        check("led_write", 32'(led_export), 32'h0F);
        bus_write(3'd5, 32'h0000_00F0);
        check("led_set", 32'(led_export), 32'hFF);
        bus_write(3'd6, 32'h0000_003C);
        check("led_clr", 32'(led_export), 32'hC3);
        bus_read(3'd5, 32'h0, "rd_led_set");
        bus_read(3'd6, 32'h0, "rd_led_clr");
        bus_read(3'd0, 32'hC3, "rd_led");
        bus_write(3'd0, 32'hFFFF_FF5A);
        bus_read(3'd0, 32'h5A, "led_upper_ignored");
        bus_write(3'd7, 32'hFFFF_FFFF);
        check("unmapped_write", 32'(led_export), 32'h5A);

        // Readdata holds while avs_read is low
        bus_write(3'd0, 32'h33);
        tick(2);
        check("rdata_hold", avs_readdata, 32'h5A);

        // Simultaneous read and write returns the pre-write value
        sb.push_back('{tag: "rw_same_cycle", exp: 32'h33});
        avs_address   = 3'd0;
        avs_writedata = 32'h11;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        pop_and_check();
        check("rw_led", 32'(led_export), 32'h11);

`ifdef GPIO_DEBOUNCE_EN
        // Switch glitch shorter than the debounce window
        switch_export = 8'h01;
        tick(3);
        switch_export = 8'h00;
        tick(10);
        bus_read(3'd1, 32'h0, "sw_glitch");
`endif

        // Held switch becomes visible after LAT edges (readdata one edge later)
        switch_export = 8'h01;
        avs_address   = 3'd1;
        avs_read      = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT) check("sw_hold_pre", avs_readdata, 32'h0);
            if (k == LAT + 1) check("sw_hold_post", avs_readdata, 32'h1);
        end
        avs_read = 1'b0;

        // Key press edge and interrupt
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, 32'h1, "rd_mask");
        key_export = 2'b10;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) check("irq_before_edge", 32'(irq), 32'h0);
            if (k == LAT) check("irq_on_edge", 32'(irq), 32'h1);
        end
        bus_read(3'd3, 32'h1, "edge_cap_press");
        bus_read(3'd2, 32'h2, "key_data_press");
        key_export = 2'b11;
        tick(LAT + 2);
        bus_read(3'd3, 32'h1, "edge_cap_release");
        bus_read(3'd2, 32'h3, "key_data_release");
        check("irq_held", 32'(irq), 32'h1);
        bus_write(3'd3, 32'h0);
        bus_read(3'd3, 32'h1, "w1c_zero");
        bus_write(3'd3, 32'h1);
        check("irq_clr", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h0, "edge_cap_clr");

        // Same-edge W1C and new edge on key 1: the set wins
        key_export = 2'b01;
        tick(LAT - 1);
        bus_write(3'd3, 32'h2);
        check("irq_masked_out", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h2, "race_set_wins");
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, 32'h0, "race_clr");
        key_export = 2'b11;
        tick(LAT + 2);

        // One-cycle key pulse
        key_export = 2'b10;
        tick();
        key_export = 2'b11;
        tick(LAT + 2);
`ifdef GPIO_DEBOUNCE_EN
        bus_read(3'd3, 32'h0, "key_pulse_rejected");
`else
        bus_read(3'd3, 32'h1, "key_pulse_captured");
        bus_write(3'd3, 32'h1);
`endif

        // Reset returns registers to their idle values
        bus_write(3'd0, 32'hA5);
        bus_read(3'd0, 32'hA5, "pre_reset_led");
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        check("reset2_led", 32'(led_export), 32'h0);
        check("reset2_irq", 32'(irq), 32'h0);
        check("reset2_rdata", avs_readdata, 32'h0);
        bus_read(3'd4, 32'h0, "reset2_mask");
        bus_read(3'd2, 32'h3, "reset2_key");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
